// File: rtl/sram_controller.sv
// Memory-stage SRAM controller: 32-bit word access over a 16-bit SRAM.
// Two halfword cycles, a fixed wait window, then a one-cycle DONE handshake.
module sram_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  wait_cnt;
  logic        is_wr;
  logic [31:0] data_q;
  logic [16:0] idx_q;

  logic [31:0] offset;
  logic [16:0] idx_in;
  logic        unused_offset;

  // Data memory is mapped from byte 1024; word index wraps at 17 bits.
  assign offset        = address - 32'd1024;
  assign idx_in        = offset[18:2];
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  // Pipeline may advance when finishing, or when idle with nothing asked.
  always_comb begin
    ready = (state == DONE) ||
            ((state == IDLE) && !rd_en && !wr_en);
  end

  // Access sequencer; SRAM pins are registered one cycle ahead of use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 2'd0;
      is_wr       <= 1'b0;
      data_q      <= 32'd0;
      idx_q       <= 17'd0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            is_wr     <= wr_en;
            data_q    <= write_data;
            idx_q     <= idx_in;
            sram_addr <= {idx_in, 1'b0};
            if (wr_en) begin
              sram_dq_out <= write_data[15:0];
              sram_dq_oe  <= 1'b1;
              sram_we_n   <= 1'b0;
            end
            state <= LOW;
          end
        end
        LOW: begin
          if (!is_wr) begin
            read_data[15:0] <= sram_dq_in;
          end else begin
            sram_dq_out <= data_q[31:16];
          end
          sram_addr <= {idx_q, 1'b1};
          state     <= HIGH;
        end
        HIGH: begin
          if (!is_wr) begin
            read_data[31:16] <= sram_dq_in;
          end
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          wait_cnt   <= 2'd0;
          state      <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd2) begin
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural 16-bit SRAM.
// Expected strobes and completions are queued; a monitor pops on events.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  sram_controller dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  logic        unused_hi;
  assign unused_hi  = ^sram_addr[17:8];
  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
  } done_t;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } strobe_t;

  done_t   done_q[$];
  strobe_t strb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare SRAM write strobes and completions as they appear.
  logic prev_ready = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b1;
    end else begin
      if (!sram_we_n) begin
        if (strb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe got addr %h data %h",
                   sram_addr, sram_dq_out);
        end else begin
          strobe_t s;
          s = strb_q.pop_front();
          check("strobe_addr", {14'd0, sram_addr}, {14'd0, s.a});
          check("strobe_data", {16'd0, sram_dq_out}, {16'd0, s.d});
          check("strobe_oe", {31'd0, sram_dq_oe}, 32'd1);
        end
      end
      if (ready && !prev_ready) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got cycle %0d", cyc);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("read_data", read_data, d.rd);
        end
      end
      prev_ready = ready;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30; i++) begin
      if (done_q.size() == 0 && strb_q.size() == 0) break;
      next();
    end
    checks++;
    if (done_q.size() != 0 || strb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout got pending %0d/%0d expected 0/0",
               done_q.size(), strb_q.size());
      done_q.delete();
      strb_q.delete();
    end
  endtask

  // One access: request for a single cycle, then drop and scramble inputs.
  task automatic access(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
    wr_en      = w;
    rd_en      = r;
    address    = a;
    write_data = wd;
    done_q.push_back('{cyc + 6, exp_rd});
    next();
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = 32'hFFFF_FFFF;
    write_data = 32'h0F0F_0F0F;
    wait_done();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[2] = 16'h1234;
    mem[3] = 16'hABCD;
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    next();
    next();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    rst = 1'b0;
    next();
    next();
    check("idle_ready", {31'd0, ready}, 32'd1);
    check("idle_we_n", {31'd0, sram_we_n}, 32'd1);

    strb_q.push_back('{18'd0, 16'hBEEF});
    strb_q.push_back('{18'd1, 16'hDEAD});
    access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 32'd0);
    check("after_write_addr", {14'd0, sram_addr}, 32'd1);

    access(1'b0, 1'b1, 32'd1028, 32'd0, 32'hABCD_1234);

    strb_q.push_back('{18'd4, 16'hC3C3});
    strb_q.push_back('{18'd5, 16'h5A5A});
    access(1'b1, 1'b1, 32'd1032, 32'h5A5A_C3C3, 32'hABCD_1234);

    access(1'b0, 1'b1, 32'd1032, 32'd0, 32'h5A5A_C3C3);

    rd_en   = 1'b1;
    address = 32'd1028;
    done_q.push_back('{cyc + 6, 32'hABCD_1234});
    done_q.push_back('{cyc + 13, 32'h5A5A_C3C3});
    repeat (7) next();
    address = 32'd1032;
    next();
    rd_en   = 1'b0;
    address = 32'hFFFF_FFFF;
    check("b2b_low_addr", {14'd0, sram_addr}, 32'd4);
    wait_done();

    wr_en      = 1'b1;
    address    = 32'd1036;
    write_data = 32'h1111_2222;
    strb_q.push_back('{18'd6, 16'h2222});
    next();
    wr_en = 1'b0;
    next();
    rst = 1'b1;
    #1;
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_read_data", read_data, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    next();
    rst = 1'b0;
    repeat (10) next();
    check("abort_ready_after", {31'd0, ready}, 32'd1);
    check("abort_no_high", {16'd0, mem[7]}, 32'd0);
    check("abort_low_done", {16'd0, mem[6]}, 32'h2222);
    check("abort_pending", strb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port wr_en, input, 1 bit: memory-stage write request.
REQ-004 SHALL have port rd_en, input, 1 bit: memory-stage read request.
REQ-005 SHALL have port address, input, 32 bits: byte address from the ALU result.
REQ-006 SHALL have port write_data, input, 32 bits: store data (Rm value).
REQ-007 SHALL have port read_data, output, 32 bits: registered load result.
REQ-008 SHALL have port ready, output, 1 bit: high means the pipeline may advance; low means freeze.
REQ-009 SHALL have port sram_addr, output, 18 bits: SRAM halfword address.
REQ-010 SHALL have port sram_dq_out, output, 16 bits: SRAM write data.
REQ-011 SHALL have port sram_dq_in, input, 16 bits: SRAM read data.
REQ-012 SHALL have port sram_dq_oe, output, 1 bit: drive enable for the data bus.
REQ-013 SHALL have port sram_we_n, output, 1 bit: active-low SRAM write strobe.

Function
REQ-014 SHALL implement FSM states IDLE, LOW, HIGH, WAIT, DONE.
REQ-015 In IDLE with rd_en or wr_en high, SHALL latch address, write_data and op type (write wins if both are high), then go to LOW next cycle.
REQ-016 SHALL form the word index as (address - 1024) bits [18:2], 17 bits with modulo wrap; SHALL set sram_addr to {index, 0} in LOW and {index, 1} in HIGH.
REQ-017 For a write in LOW/HIGH, SHALL drive sram_dq_out = latched data [15:0] / [31:16], with sram_dq_oe=1 and sram_we_n=0.
REQ-018 For a read in LOW/HIGH, SHALL keep sram_dq_oe=0 and sram_we_n=1, and capture sram_dq_in at cycle end into read_data [15:0] / [31:16].
REQ-019 In IDLE, WAIT and DONE, SHALL hold sram_we_n=1, sram_dq_oe=0 and sram_addr at its last value.
REQ-020 LOW goes to HIGH, then WAIT; SHALL stay in WAIT for exactly 3 cycles (2-bit counter, cleared on entry), then go to DONE; DONE goes to IDLE unconditionally.
REQ-021 SHALL compute ready combinationally as (state==DONE) or (state==IDLE and rd_en==0 and wr_en==0); it is therefore low from the request cycle through WAIT.
REQ-022 Latency SHALL be fixed: request first seen in IDLE at cycle 0 gives ready=1 at cycle 6, for both read and write.
REQ-023 read_data SHALL be valid at DONE and held until the next read's LOW/HIGH capture; writes SHALL NOT modify read_data.
REQ-024 Changes or deassertion of rd_en/wr_en after acceptance SHALL be ignored; the operation always completes.
REQ-025 A request still present in the cycle after DONE SHALL be treated as a new access.

Reset
REQ-026 On rst, SHALL asynchronously set state=IDLE, WAIT counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
REQ-027 Reset asserted mid-operation SHALL abort the access with no further SRAM strobes; after release, ready SHALL follow the IDLE rule.

Verification
REQ-028 Idle with rd_en=wr_en=0 -> ready=1, sram_we_n=1, sram_dq_oe=0.
REQ-029 Write 0xDEADBEEF to address 1024 -> cycle 1 sram_addr=0, dq_out=0xBEEF, we_n=0; cycle 2 sram_addr=1, dq_out=0xDEAD; cycles 0-5 ready=0; cycle 6 ready=1.
REQ-030 Read address 1028 with the SRAM model returning 0x1234 at addr 2 and 0xABCD at addr 3 -> read_data=0xABCD1234 and ready=1 at cycle 6.
REQ-031 rd_en=wr_en=1 with address 1032 -> write performed at sram_addr 4/5, and read_data unchanged.
REQ-032 rst pulsed during HIGH of a write -> sram_we_n=1 immediately, state IDLE, read_data=0, and no write at the next halfword.
REQ-033 Back-to-back reads held high across DONE -> second access starts with its LOW at cycle 8, and ready=1 again at cycle 13.
